dmem_arbiter: RTL and testbench

Two-master arbiter for the data memory port. It shares the single `data_mem` block-RAM port between the CPU load/store unit (master 0) and the loader/debug DMA (master 1). Requests are granted round-robin, with an optional lock for atomic multi-beat sequences. Each read's owner is tracked through the BRAM read latency so that read data returns to the master that issued it.

---
 rtl/dmem_arb_pkg.sv | 23 ++
 rtl/rr_arb2.sv | 24 ++
 rtl/dmem_arbiter.sv | 155 +++++++++++++++
 tb/tb_dmem_arbiter.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
//   - FSM state encoding (ARB / LOCK0 / LOCK1)
//   - master index constants
//   - read-return tag carried through the BRAM latency pipeline
package dmem_arb_pkg;

  // FSM state encoding
  typedef logic [1:0] state_t;
  localparam state_t ST_ARB   = 2'd0;
  localparam state_t ST_LOCK0 = 2'd1;
  localparam state_t ST_LOCK1 = 2'd2;

  // Master indices
  localparam logic M_CPU = 1'b0;
  localparam logic M_DMA = 1'b1;

  // Read-return tag: one per issued beat, valid only for reads
  typedef struct packed {
    logic valid;
    logic owner;
  } rd_tag_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker (purely combinational).
//   req  : request vector, bit n = master n
//   last : index of the most recently granted master
//   mask : eligibility mask, bit n = master n may be granted
//   gnt  : one-hot grant (all zero when nothing eligible)
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  input  logic [1:0] mask,
  output logic [1:0] gnt
);

  logic [1:0] elig;

  // On a tie the master opposite the last winner is chosen
  always_comb begin
    elig = req & mask;
    gnt  = elig;
    if (elig == 2'b11) begin
      gnt = last ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-master arbiter for the single data_mem BRAM port.
//   m0_* : CPU load/store unit   m1_* : loader/debug DMA
//   mN_req/we/lock/addr/wdata in, mN_gnt (0-cycle grant), mN_rvalid/rdata out
//   mem_en/we/addr/din drive data_mem, mem_dout returns its read data
// Round-robin between masters, optional lock for atomic sequences, and a
// tag pipeline RD_LAT deep (legal values 1 or 2) that routes read data back
// to the master that issued the read.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              m0_req,
  input  logic              m0_we,
  input  logic              m0_lock,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,

  input  logic              m1_req,
  input  logic              m1_we,
  input  logic              m1_lock,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,

  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout
);

  localparam int unsigned LAST = RD_LAT - 1;

  state_t               state_q, state_d;
  logic                 last_q, last_d;
  rd_tag_t [RD_LAT-1:0] tag_q, tag_d;
  rd_tag_t              tag_in;

  logic [1:0] req, mask, pick, gnt;
  logic       gnt_any, gnt_idx, gnt_lock;

  assign req = {m1_req, m0_req};

  // A lock restricts eligibility to its holder
  always_comb begin
    mask = 2'b11;
    case (state_q)
      ST_LOCK0: mask = 2'b01;
      ST_LOCK1: mask = 2'b10;
      default:  mask = 2'b11;
    endcase
  end

  rr_arb2 u_rr_arb2 (
    .req  (req),
    .last (last_q),
    .mask (mask),
    .gnt  (pick)
  );

  // No grant may escape while reset is held
  assign gnt      = pick & {2{rst_n}};
  assign gnt_any  = |gnt;
  assign gnt_idx  = gnt[1];
  assign gnt_lock = (gnt[0] & m0_lock) | (gnt[1] & m1_lock);
  assign m0_gnt   = gnt[0];
  assign m1_gnt   = gnt[1];

  // Memory port mux; idle outputs parked at zero
  always_comb begin
    mem_en   = gnt_any;
    mem_we   = 1'b0;
    mem_addr = '0;
    mem_din  = '0;
    if (gnt[0]) begin
      mem_we   = m0_we;
      mem_addr = m0_addr;
      mem_din  = m0_wdata;
    end else if (gnt[1]) begin
      mem_we   = m1_we;
      mem_addr = m1_addr;
      mem_din  = m1_wdata;
    end
  end

  // Next state / last-winner update
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    if (gnt_any) begin
      last_d = gnt_idx;
    end
    case (state_q)
      ST_ARB: begin
        if (gnt_any && gnt_lock) begin
          state_d = gnt_idx ? ST_LOCK1 : ST_LOCK0;
        end
      end
      ST_LOCK0: begin
        if (gnt[0] && !m0_lock) begin
          state_d = ST_ARB;
        end
      end
      ST_LOCK1: begin
        if (gnt[1] && !m1_lock) begin
          state_d = ST_ARB;
        end
      end
      default: state_d = ST_ARB;
    endcase
  end

  // Writes and idle cycles push an invalid tag
  always_comb begin
    tag_in       = '0;
    tag_in.valid = gnt_any & ~mem_we;
    tag_in.owner = gnt_idx;
  end

  if (RD_LAT > 1) begin : g_tag_shift
    assign tag_d = {tag_q[RD_LAT-2:0], tag_in};
  end else begin : g_tag_single
    assign tag_d = tag_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_ARB;
      last_q  <= M_DMA;
      tag_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      tag_q   <= tag_d;
    end
  end

  // Tag in the last stage lines up with mem_dout
  assign m0_rvalid = tag_q[LAST].valid & (tag_q[LAST].owner == M_CPU);
  assign m1_rvalid = tag_q[LAST].valid & (tag_q[LAST].owner == M_DMA);
  assign m0_rdata  = mem_dout;
  assign m1_rdata  = mem_dout;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench: two arbiters (RD_LAT=1 and RD_LAT=2) share the same
// master stimulus; each has its own BRAM read path over one memory array.
module tb_dmem_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        m0_req, m0_we, m0_lock, m1_req, m1_we, m1_lock;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;

  logic        d1_m0_gnt, d1_m0_rvalid, d1_m1_gnt, d1_m1_rvalid;
  logic        d1_mem_en, d1_mem_we;
  logic [31:0] d1_m0_rdata, d1_m1_rdata, d1_mem_addr, d1_mem_din, d1_mem_dout;
  logic        d2_m0_gnt, d2_m0_rvalid, d2_m1_gnt, d2_m1_rvalid;
  logic        d2_mem_en, d2_mem_we;
  logic [31:0] d2_m0_rdata, d2_m1_rdata, d2_mem_addr, d2_mem_din, d2_mem_dout;

  dmem_arbiter #(.DATA_W(32), .ADDR_W(32), .RD_LAT(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_lock(m0_lock), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_gnt(d1_m0_gnt), .m0_rvalid(d1_m0_rvalid), .m0_rdata(d1_m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_gnt(d1_m1_gnt), .m1_rvalid(d1_m1_rvalid), .m1_rdata(d1_m1_rdata),
    .mem_en(d1_mem_en), .mem_we(d1_mem_we), .mem_addr(d1_mem_addr), .mem_din(d1_mem_din),
    .mem_dout(d1_mem_dout)
  );

  dmem_arbiter #(.DATA_W(32), .ADDR_W(32), .RD_LAT(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_lock(m0_lock), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_gnt(d2_m0_gnt), .m0_rvalid(d2_m0_rvalid), .m0_rdata(d2_m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_gnt(d2_m1_gnt), .m1_rvalid(d2_m1_rvalid), .m1_rdata(d2_m1_rdata),
    .mem_en(d2_mem_en), .mem_we(d2_mem_we), .mem_addr(d2_mem_addr), .mem_din(d2_mem_din),
    .mem_dout(d2_mem_dout)
  );

  // BRAM model: array preloaded with addr*3, written through the RD_LAT=2 port
  logic [31:0] mem [4096];
  logic        loaded = 1'b0;
  logic [31:0] d2_stage;
  always @(posedge clk) begin
    if (!loaded) begin
      for (int i = 0; i < 4096; i++) mem[i] <= 32'(i * 3);
      loaded <= 1'b1;
    end else if (d2_mem_en && d2_mem_we) begin
      mem[d2_mem_addr[11:0]] <= d2_mem_din;
    end
    if (d1_mem_en) d1_mem_dout <= mem[d1_mem_addr[11:0]];
    if (d2_mem_en) d2_stage <= mem[d2_mem_addr[11:0]];
    d2_mem_dout <= d2_stage;
  end

  int n_pass = 0;
  int n_tot  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic drv0(input logic req, input logic we, input logic lock,
                      input logic [31:0] addr, input logic [31:0] wdata);
    m0_req = req; m0_we = we; m0_lock = lock; m0_addr = addr; m0_wdata = wdata;
  endtask

  task automatic drv1(input logic req, input logic we, input logic lock,
                      input logic [31:0] addr, input logic [31:0] wdata);
    m1_req = req; m1_we = we; m1_lock = lock; m1_addr = addr; m1_wdata = wdata;
  endtask

  logic [31:0] exp_addr [8];

  initial begin
    rst_n = 1'b1;
    drv0(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    drv1(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    #2;
    // Reset held with both masters requesting
    rst_n = 1'b0;
    drv0(1'b1, 1'b0, 1'b0, 32'h20, 32'h0);
    drv1(1'b1, 1'b0, 1'b0, 32'h21, 32'h0);
    repeat (2) @(posedge clk);
    mid();
    chk("rst_gnt2", 32'({d2_m1_gnt, d2_m0_gnt}), 32'h0);
    chk("rst_gnt1", 32'({d1_m1_gnt, d1_m0_gnt}), 32'h0);
    chk("rst_mem_en", 32'(d2_mem_en), 32'h0);
    chk("rst_rvalid", 32'({d2_m1_rvalid, d2_m0_rvalid}), 32'h0);

    // First tie after release goes to M0, then M1
    next_cycle(); rst_n = 1'b1;
    mid();
    chk("tie0_gnt2", 32'({d2_m1_gnt, d2_m0_gnt}), 32'h1);
    chk("tie0_gnt1", 32'({d1_m1_gnt, d1_m0_gnt}), 32'h1);
    chk("tie0_addr", d2_mem_addr, 32'h20);
    next_cycle();
    mid();
    chk("tie1_gnt", 32'({d2_m1_gnt, d2_m0_gnt}), 32'h2);
    chk("tie1_addr", d2_mem_addr, 32'h21);
    chk("tie_l1_rv0", 32'({d1_m1_rvalid, d1_m0_rvalid}), 32'h1);
    chk("tie_l1_rd0", d1_m0_rdata, 32'h60);
    next_cycle(); drv0(1'b0, 1'b0, 1'b0, 32'h0, 32'h0); drv1(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    mid();
    chk("idle_gnt", 32'({d2_m1_gnt, d2_m0_gnt}), 32'h0);
    chk("idle_mem_en", 32'(d2_mem_en), 32'h0);
    chk("tie_l2_rv0", 32'({d2_m1_rvalid, d2_m0_rvalid}), 32'h1);
    chk("tie_l2_rd0", d2_m0_rdata, 32'h60);
    chk("tie_l1_rv1", 32'({d1_m1_rvalid, d1_m0_rvalid}), 32'h2);
    chk("tie_l1_rd1", d1_m1_rdata, 32'h63);
    next_cycle();
    mid();
    chk("tie_l2_rv1", 32'({d2_m1_rvalid, d2_m0_rvalid}), 32'h2);
    chk("tie_l2_rd1", d2_m1_rdata, 32'h63);

    // Write by M0 then read of the same word by M1
    next_cycle(); drv0(1'b1, 1'b1, 1'b0, 32'h10, 32'hDEADBEEF);
    mid();
    chk("raw_wgnt", 32'({d2_m1_gnt, d2_m0_gnt}), 32'h1);
    chk("raw_mem_we", 32'(d2_mem_we), 32'h1);
    chk("raw_mem_din", d2_mem_din, 32'hDEADBEEF);
    chk("raw_mem_addr", d2_mem_addr, 32'h10);
    next_cycle(); drv0(1'b0, 1'b0, 1'b0, 32'h0, 32'h0); drv1(1'b1, 1'b0, 1'b0, 32'h10, 32'h0);
    mid();
    chk("raw_rgnt", 32'({d2_m1_gnt, d2_m0_gnt}), 32'h2);
    chk("raw_rd_we", 32'(d2_mem_we), 32'h0);
    next_cycle(); drv1(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    mid();
    chk("raw_l1_rv", 32'({d1_m1_rvalid, d1_m0_rvalid}), 32'h2);
    chk("raw_l1_rd", d1_m1_rdata, 32'hDEADBEEF);
    chk("raw_l2_wr_norv", 32'({d2_m1_rvalid, d2_m0_rvalid}), 32'h0);
    next_cycle();
    mid();
    chk("raw_l2_rv", 32'({d2_m1_rvalid, d2_m0_rvalid}), 32'h2);
    chk("raw_l2_rd", d2_m1_rdata, 32'hDEADBEEF);

    // Both masters stream reads for 8 cycles
    for (int k = 0; k < 10; k++) begin
      next_cycle();
      if (k < 8) begin
        drv0(1'b1, 1'b0, 1'b0, 32'h100 + 32'((k + 1) / 2), 32'h0);
        drv1(1'b1, 1'b0, 1'b0, 32'h200 + 32'(k / 2), 32'h0);
        exp_addr[k] = ((k % 2) == 0) ? 32'h100 + 32'(k / 2) : 32'h200 + 32'(k / 2);
      end else begin
        drv0(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        drv1(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      end
      mid();
      if (k < 8) begin
        chk($sformatf("strm_gnt%0d", k), 32'({d2_m1_gnt, d2_m0_gnt}), ((k % 2) == 0) ? 32'h1 : 32'h2);
        chk($sformatf("strm_addr%0d", k), d2_mem_addr, exp_addr[k]);
      end
      if (k >= 1 && k <= 8) begin
        chk($sformatf("strm_l1_rv%0d", k - 1), 32'({d1_m1_rvalid, d1_m0_rvalid}),
            (((k - 1) % 2) == 0) ? 32'h1 : 32'h2);
        chk($sformatf("strm_l1_rd%0d", k - 1), (((k - 1) % 2) == 0) ? d1_m0_rdata : d1_m1_rdata,
            exp_addr[k - 1] * 3);
      end
      if (k >= 2) begin
        chk($sformatf("strm_l2_rv%0d", k - 2), 32'({d2_m1_rvalid, d2_m0_rvalid}),
            (((k - 2) % 2) == 0) ? 32'h1 : 32'h2);
        chk($sformatf("strm_l2_rd%0d", k - 2), (((k - 2) % 2) == 0) ? d2_m0_rdata : d2_m1_rdata,
            exp_addr[k - 2] * 3);
      end
    end

    // Lock: M1 holds the port for beats lock=1,1,0 while M0 keeps asking
    next_cycle(); drv0(1'b1, 1'b1, 1'b0, 32'h40, 32'hA0);
    mid();
    chk("lk_pre_gnt", 32'({d2_m1_gnt, d2_m0_gnt}), 32'h1);
    next_cycle(); drv0(1'b1, 1'b1, 1'b0, 32'h41, 32'hA1); drv1(1'b1, 1'b1, 1'b1, 32'h30, 32'hB0);
    mid();
    chk("lk_b0_gnt", 32'({d2_m1_gnt, d2_m0_gnt}), 32'h2);
    next_cycle(); drv1(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    mid();
    chk("lk_gap_gnt", 32'({d2_m1_gnt, d2_m0_gnt}), 32'h0);
    chk("lk_gap_en", 32'(d2_mem_en), 32'h0);
    next_cycle(); drv1(1'b1, 1'b1, 1'b1, 32'h31, 32'hB1);
    mid();
    chk("lk_b1_gnt", 32'({d2_m1_gnt, d2_m0_gnt}), 32'h2);
    chk("lk_wr_norv", 32'({d2_m1_rvalid, d2_m0_rvalid}), 32'h0);
    next_cycle(); drv1(1'b1, 1'b1, 1'b0, 32'h32, 32'hB2);
    mid();
    chk("lk_b2_gnt", 32'({d2_m1_gnt, d2_m0_gnt}), 32'h2);
    chk("lk_b2_din", d2_mem_din, 32'hB2);
    next_cycle(); drv1(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    mid();
    chk("lk_rel_gnt", 32'({d2_m1_gnt, d2_m0_gnt}), 32'h1);
    chk("lk_rel_addr", d2_mem_addr, 32'h41);

    // Reset pulse one cycle after a read grant drops the in-flight tag
    next_cycle(); drv0(1'b1, 1'b0, 1'b0, 32'h50, 32'h0);
    mid();
    chk("rp_rd_gnt", 32'({d2_m1_gnt, d2_m0_gnt}), 32'h1);
    next_cycle(); rst_n = 1'b0; drv0(1'b1, 1'b0, 1'b0, 32'h60, 32'h0); drv1(1'b1, 1'b0, 1'b0, 32'h61, 32'h0);
    mid();
    chk("rp_gnt_in_rst", 32'({d2_m1_gnt, d2_m0_gnt}), 32'h0);
    chk("rp_l2_rv_in_rst", 32'({d2_m1_rvalid, d2_m0_rvalid}), 32'h0);
    chk("rp_l1_rv_in_rst", 32'({d1_m1_rvalid, d1_m0_rvalid}), 32'h0);
    next_cycle(); rst_n = 1'b1;
    mid();
    chk("rp_tie_gnt", 32'({d2_m1_gnt, d2_m0_gnt}), 32'h1);
    chk("rp_dropped_rv", 32'({d2_m1_rvalid, d2_m0_rvalid}), 32'h0);
    next_cycle(); drv0(1'b0, 1'b0, 1'b0, 32'h0, 32'h0); drv1(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    mid();
    chk("rp_l2_quiet", 32'({d2_m1_rvalid, d2_m0_rvalid}), 32'h0);
    chk("rp_l1_rv", 32'({d1_m1_rvalid, d1_m0_rvalid}), 32'h1);
    chk("rp_l1_rd", d1_m0_rdata, 32'h120);
    next_cycle();
    mid();
    chk("rp_l2_rv", 32'({d2_m1_rvalid, d2_m0_rvalid}), 32'h1);
    chk("rp_l2_rd", d2_m0_rdata, 32'h120);

    // Single read at 0x0FF: rvalid exactly RD_LAT cycles after grant
    next_cycle(); drv0(1'b1, 1'b0, 1'b0, 32'hFF, 32'h0);
    mid();
    chk("s_gnt", 32'(d1_m0_gnt), 32'h1);
    chk("s_l1_rv_c0", 32'({d1_m1_rvalid, d1_m0_rvalid}), 32'h0);
    next_cycle(); drv0(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    mid();
    chk("s_l1_rv_c1", 32'({d1_m1_rvalid, d1_m0_rvalid}), 32'h1);
    chk("s_l1_rd", d1_m0_rdata, 32'h2FD);
    chk("s_l2_rv_c1", 32'({d2_m1_rvalid, d2_m0_rvalid}), 32'h0);
    next_cycle();
    mid();
    chk("s_l1_rv_c2", 32'({d1_m1_rvalid, d1_m0_rvalid}), 32'h0);
    chk("s_l2_rv_c2", 32'({d2_m1_rvalid, d2_m0_rvalid}), 32'h1);
    chk("s_l2_rd", d2_m0_rdata, 32'h2FD);
    next_cycle();
    mid();
    chk("s_l2_rv_c3", 32'({d2_m1_rvalid, d2_m0_rvalid}), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
